// File: rtl/hex_rx_assembler.sv
// rtl/hex_rx_assembler.sv - assembles ASCII hex character pairs from a UART into bytes
module hex_rx_assembler #(
    parameter logic ACCEPT_LOWER = 1'b1,
    parameter logic FLUSH_ODD    = 1'b1
) (
    input  logic       CLK,
    input  logic       resetn,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       line_end,
    output logic [7:0] line_count,
    output logic       err_char,
    output logic       overrun
);

    typedef enum logic {S_HI = 1'b0, S_LO = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] hi_q, hi_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       line_end_q, line_end_d;
    logic [7:0] line_count_q, line_count_d;
    logic       err_char_q, err_char_d;
    logic       overrun_q, overrun_d;

    logic       is_num, is_upper, is_lower, is_hex, is_term, is_sep;
    logic [3:0] digit;
    logic       offer;
    logic [7:0] new_byte;
    logic [7:0] count_base;

    always_comb begin
        is_num   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_upper = (rx_data >= 8'h41) && (rx_data <= 8'h46);
        is_lower = ACCEPT_LOWER && (rx_data >= 8'h61) && (rx_data <= 8'h66);
        is_hex   = is_num || is_upper || is_lower;
        is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        is_sep   = (rx_data == 8'h20);
        // Letters have 1..6 in the low nibble for both cases, so add 9 to reach 10..15.
        digit    = is_num ? rx_data[3:0] : rx_data[3:0] + 4'd9;
    end

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        line_end_d = 1'b0;
        err_char_d = 1'b0;
        offer      = 1'b0;
        new_byte   = 8'h00;
        if (rx_valid) begin
            if (is_hex) begin
                if (state_q == S_HI) begin
                    hi_d    = digit;
                    state_d = S_LO;
                end else begin
                    offer    = 1'b1;
                    new_byte = {hi_q, digit};
                    hi_d     = 4'h0;
                    state_d  = S_HI;
                end
            end else if (is_sep || is_term) begin
                if (state_q == S_LO) begin
                    if (FLUSH_ODD) begin
                        offer    = 1'b1;
                        new_byte = {4'h0, hi_q};
                    end else begin
                        err_char_d = 1'b1;
                    end
                end
                hi_d       = 4'h0;
                state_d    = S_HI;
                line_end_d = is_term;
            end else begin
                err_char_d = 1'b1;
                hi_d       = 4'h0;
                state_d    = S_HI;
            end
        end
    end

    // The count restarts on the edge after line_end, so a byte landing on that edge starts the new line.
    always_comb begin
        count_base   = line_end_q ? 8'h00 : line_count_q;
        line_count_d = (offer && (count_base != 8'hFF)) ? count_base + 8'h01 : count_base;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        overrun_d   = 1'b0;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (offer) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = new_byte;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_HI;
            hi_q         <= 4'h0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            line_end_q   <= 1'b0;
            line_count_q <= 8'h00;
            err_char_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            line_end_q   <= line_end_d;
            line_count_q <= line_count_d;
            err_char_q   <= err_char_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign line_end   = line_end_q;
    assign line_count = line_count_q;
    assign err_char   = err_char_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/hex_rx_assembler.md
HEX_RX_ASSEMBLER -- requirements
Module: hex_rx_assembler

Interface
REQ-001 The block SHALL have parameter ACCEPT_LOWER, default 1, which when 1 makes 'a'-'f' valid hex digits in addition to 'A'-'F'.
REQ-002 The block SHALL have parameter FLUSH_ODD, default 1, which when 1 emits a lone pending high nibble as byte {4'h0, nibble} at a terminator; when 0 the nibble is discarded with an error.
REQ-003 The block SHALL run on a single clock and SHALL use an asynchronous, active-low reset.
REQ-004 CLK  input  1  system clock, 12 MHz.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 rx_valid  input  1  one-cycle pulse from uart_rx: rx_data holds a received character.
REQ-007 rx_data  input  8  received ASCII character, sampled only when rx_valid=1.
REQ-008 out_valid  output  1  out_data holds an assembled byte.
REQ-009 out_data  output  8  assembled byte value.
REQ-010 out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1 at the same edge.
REQ-011 line_end  output  1  one-cycle pulse on CR (0x0D) or LF (0x0A).
REQ-012 line_count  output  8  bytes emitted since the previous line_end; valid in the line_end cycle.
REQ-013 err_char  output  1  one-cycle pulse on an illegal character or on a dropped odd nibble.
REQ-014 overrun  output  1  one-cycle pulse when a completed byte is dropped because the output register is occupied.

Function
REQ-015 The decoder FSM SHALL have two states: S_HI (no pending nibble) and S_LO (high nibble stored in an internal 4-bit register).
REQ-016 Characters SHALL be classified as follows:
- '0'-'9' (0x30-0x39) map to values 0-9.
- 'A'-'F' (0x41-0x46) map to values 10-15.
- 'a'-'f' (0x61-0x66) map to values 10-15 only when ACCEPT_LOWER=1.
- CR/LF are terminators.
- Space (0x20) is a separator.
- All other characters are illegal.
REQ-017 In S_HI, a hex digit SHALL be stored as the high nibble and the FSM SHALL go to S_LO.
REQ-018 In S_LO, a hex digit SHALL complete byte {hi, digit}, which is offered to the output stage, and the FSM SHALL go to S_HI.
REQ-019 In S_HI, a separator SHALL be ignored, with no output activity.
REQ-020 In S_LO, a separator SHALL act as an odd flush per REQ-002, with no line_end pulse, and the FSM SHALL go to S_HI.
REQ-021 A terminator SHALL pulse line_end in the cycle after the sample edge. In S_LO it SHALL first perform an odd flush per REQ-002, and the flushed byte SHALL be counted in that line_count. The FSM SHALL then go to S_HI.
REQ-022 An illegal character SHALL:
- pulse err_char;
- discard any pending nibble;
- force S_HI;
- leave line_count unchanged.
REQ-023 Latency: out_valid, line_end, err_char and overrun SHALL assert in the cycle immediately following the CLK edge at which rx_valid=1 was sampled.
REQ-024 out_valid SHALL stay high, with out_data stable, until an edge with out_ready=1. After that edge out_valid SHALL drop, unless a new byte loads at the same edge.
REQ-025 If a byte completes at an edge where out_valid=1 and out_ready=1, the new byte SHALL load, out_valid SHALL stay 1, and no overrun SHALL occur.
REQ-026 If a byte completes at an edge where out_valid=1 and out_ready=0, the new byte SHALL be dropped, the held byte SHALL stay unchanged, and overrun SHALL pulse.
REQ-027 line_count SHALL increment for each byte offered to the output stage, including overrun-dropped bytes.
REQ-028 line_count SHALL saturate at 255.
REQ-029 line_count SHALL clear to 0 on the edge following the line_end cycle.
REQ-030 rx_valid pulses arrive at most once per character time, so no character SHALL arrive while a pulse is being processed; no input buffering is required.

Reset
REQ-031 While resetn=0, the FSM SHALL be in S_HI and the pending nibble SHALL be 0.
REQ-032 While resetn=0, the outputs SHALL be: out_valid=0, out_data=0x00, line_end=0, line_count=0, err_char=0, overrun=0.
REQ-033 Reset asserted mid-byte (in S_LO) or while out_valid=1 SHALL discard all pending data. After release, the block SHALL start in S_HI.

Verification
REQ-034 Stream "4","1",CR with out_ready=1 -> out_valid one cycle with out_data=0x41, then line_end with line_count=1; err_char=0.
REQ-035 ACCEPT_LOWER=1, stream "f","F"," ","0","a" with out_ready=1 -> bytes 0xFF then 0x0A; no err_char.
REQ-036 FLUSH_ODD=1, stream "7",LF -> byte 0x07 plus line_end with line_count=1; with FLUSH_ODD=0 -> no byte, err_char pulse, line_end with line_count=0.
REQ-037 out_ready=0, stream "12","34" -> out_data stays 0x12 and overrun pulses once; then out_ready=1 for one edge -> out_valid drops.
REQ-038 Stream "3","G","5","6" -> err_char on 'G', first nibble discarded, single byte 0x56.
REQ-039 Stream "9", then resetn low for 2 cycles, then "8","8" -> single byte 0x88; all outputs 0 during reset.
